// File: rtl/cpu_sequencer.sv
// cpu_sequencer: Moore fetch/decode/execute control FSM for the 16-bit register/ALU datapath.
// Define CPU_SEQ_LDST_EN to compile the LDR/STR address and memory-access states.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic [1:0] ALU_op,
  output logic       load_pc,
  output logic       clear_pc,
  output logic       load_ir,
  output logic       load_addr,
  output logic       sel_addr,
  output logic [1:0] mem_cmd,
  output logic [1:0] reg_sel,
  output logic [1:0] wb_sel,
  output logic       w_en,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_status,
  output logic       sel_A,
  output logic       sel_B,
  output logic       halted
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WRITE_IMM,
    S_READ_A, S_READ_B, S_EXEC, S_WRITE_RD,
`ifdef CPU_SEQ_LDST_EN
    S_ADDR, S_LOAD_ADDR, S_MEM_RD1, S_MEM_RD2, S_WRITE_MEM,
    S_READ_RD, S_PASS_B, S_MEM_WR,
`endif
    S_HALT
  } state_t;

  typedef struct packed {
    logic       load_pc;
    logic       clear_pc;
    logic       load_ir;
`ifdef CPU_SEQ_LDST_EN
    logic       load_addr;
`endif
    logic       sel_addr;
    logic [1:0] mem_cmd;
    logic [1:0] reg_sel;
    logic [1:0] wb_sel;
    logic       w_en;
    logic       en_a;
    logic       en_b;
    logic       en_c;
    logic       en_status;
    logic       sel_a;
    logic       sel_b;
    logic       halted;
  } ctl_t;

  localparam logic [1:0] MEM_READ = 2'b01;
  localparam logic [1:0] RS_RN    = 2'b10;
  localparam logic [1:0] RS_RD    = 2'b01;
  localparam logic [1:0] RS_RM    = 2'b00;
  localparam logic [1:0] WB_C     = 2'b00;
  localparam logic [1:0] WB_IMM   = 2'b10;
`ifdef CPU_SEQ_LDST_EN
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] WB_MDATA  = 2'b11;
`endif

  state_t state_reg, state_next;
  ctl_t   ctl_reg, ctl_next;

  logic is_mov_imm, is_mov_rm, is_alu, is_mvn, is_cmp, is_halt;
  assign is_mov_imm = (opcode == 3'b110) && (ALU_op == 2'b10);
  assign is_mov_rm  = (opcode == 3'b110) && (ALU_op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_mvn     = is_alu && (ALU_op == 2'b11);
  assign is_cmp     = is_alu && (ALU_op == 2'b01);
  assign is_halt    = (opcode == 3'b111);
`ifdef CPU_SEQ_LDST_EN
  logic is_ldr, is_str;
  assign is_ldr = (opcode == 3'b011);
  assign is_str = (opcode == 3'b100);
`endif

  // Control word for a state; EXEC is the only state whose word depends on the instruction.
  function automatic ctl_t ctl_for(input state_t s, input logic pass_b, input logic set_status);
    ctl_t c;
    c = '0;
    case (s)
      S_RST:       begin c.clear_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:       begin c.sel_addr = 1'b1; c.mem_cmd = MEM_READ; end
      S_IF2:       begin c.sel_addr = 1'b1; c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
      S_UPDATE_PC: c.load_pc = 1'b1;
      S_WRITE_IMM: begin c.reg_sel = RS_RN; c.wb_sel = WB_IMM; c.w_en = 1'b1; end
      S_READ_A:    begin c.reg_sel = RS_RN; c.en_a = 1'b1; end
      S_READ_B:    begin c.reg_sel = RS_RM; c.en_b = 1'b1; end
      S_EXEC:      begin c.en_c = 1'b1; c.sel_a = pass_b; c.en_status = set_status; end
      S_WRITE_RD:  begin c.reg_sel = RS_RD; c.wb_sel = WB_C; c.w_en = 1'b1; end
`ifdef CPU_SEQ_LDST_EN
      S_ADDR:      begin c.sel_b = 1'b1; c.en_c = 1'b1; end
      S_LOAD_ADDR: c.load_addr = 1'b1;
      S_MEM_RD1,
      S_MEM_RD2:   c.mem_cmd = MEM_READ;
      S_WRITE_MEM: begin
        c.mem_cmd = MEM_READ; c.reg_sel = RS_RD; c.wb_sel = WB_MDATA; c.w_en = 1'b1;
      end
      S_READ_RD:   begin c.reg_sel = RS_RD; c.en_b = 1'b1; end
      S_PASS_B:    begin c.sel_a = 1'b1; c.en_c = 1'b1; end
      S_MEM_WR:    c.mem_cmd = MEM_WRITE;
`endif
      S_HALT:      c.halted = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST:       state_next = S_IF1;
      S_IF1:       state_next = S_IF2;
      S_IF2:       state_next = S_UPDATE_PC;
      S_UPDATE_PC: state_next = S_DECODE;
      S_DECODE: begin
        state_next = S_IF1;
        if (is_mov_imm)                  state_next = S_WRITE_IMM;
        else if (is_mov_rm || is_mvn)    state_next = S_READ_B;
        else if (is_alu)                 state_next = S_READ_A;
`ifdef CPU_SEQ_LDST_EN
        else if (is_ldr || is_str)       state_next = S_READ_A;
`endif
        else if (is_halt)                state_next = S_HALT;
      end
      S_WRITE_IMM: state_next = S_IF1;
      S_READ_A: begin
        state_next = S_READ_B;
`ifdef CPU_SEQ_LDST_EN
        if (is_ldr || is_str) state_next = S_ADDR;
`endif
      end
      S_READ_B:    state_next = S_EXEC;
      S_EXEC:      state_next = is_cmp ? S_IF1 : S_WRITE_RD;
      S_WRITE_RD:  state_next = S_IF1;
`ifdef CPU_SEQ_LDST_EN
      S_ADDR:      state_next = S_LOAD_ADDR;
      S_LOAD_ADDR: state_next = is_ldr ? S_MEM_RD1 : S_READ_RD;
      S_MEM_RD1:   state_next = S_MEM_RD2;
      S_MEM_RD2:   state_next = S_WRITE_MEM;
      S_WRITE_MEM: state_next = S_IF1;
      S_READ_RD:   state_next = S_PASS_B;
      S_PASS_B:    state_next = S_MEM_WR;
      S_MEM_WR:    state_next = S_IF1;
`endif
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_RST;
    endcase
  end

  // Outputs are registered alongside the state, so they are computed from the next state.
  assign ctl_next = ctl_for(state_next, is_mov_rm || is_mvn, is_alu);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RST;
      ctl_reg   <= ctl_for(S_RST, 1'b0, 1'b0);
    end else begin
      state_reg <= state_next;
      ctl_reg   <= ctl_next;
    end
  end

  assign load_pc   = ctl_reg.load_pc;
  assign clear_pc  = ctl_reg.clear_pc;
  assign load_ir   = ctl_reg.load_ir;
`ifdef CPU_SEQ_LDST_EN
  assign load_addr = ctl_reg.load_addr;
`else
  assign load_addr = 1'b0;
`endif
  assign sel_addr  = ctl_reg.sel_addr;
  assign mem_cmd   = ctl_reg.mem_cmd;
  assign reg_sel   = ctl_reg.reg_sel;
  assign wb_sel    = ctl_reg.wb_sel;
  assign w_en      = ctl_reg.w_en;
  assign en_A      = ctl_reg.en_a;
  assign en_B      = ctl_reg.en_b;
  assign en_C      = ctl_reg.en_c;
  assign en_status = ctl_reg.en_status;
  assign sel_A     = ctl_reg.sel_a;
  assign sel_B     = ctl_reg.sel_b;
  assign halted    = ctl_reg.halted;

endmodule
